// File: rtl/cic_comp_pkg.sv
// Shared constants for the CIC droop-compensation FIR: tap count, coefficient set,
// FSM state encoding and accumulator sizing.
package cic_comp_pkg;

    localparam int NTAPS      = 21;
    localparam int CIC_COEF_W = 18;

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    // Q1.17, symmetric; DC gain is about 1.56 to lift the CIC passband droop.
    localparam logic signed [CIC_COEF_W-1:0] COEF [NTAPS] = '{
        -18'sd124,   -18'sd260,   18'sd516,    18'sd1020,  -18'sd2048,
        -18'sd3072,   18'sd4096,  18'sd8192,  -18'sd8192,   18'sd40960,
         18'sd122880,
         18'sd40960, -18'sd8192,  18'sd8192,   18'sd4096,  -18'sd3072,
        -18'sd2048,   18'sd1020,  18'sd516,   -18'sd260,   -18'sd124
    };

    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/cic_comp_scale.sv
// One channel of input scaling: round-half-up, arithmetic shift by SHIFT,
// saturate to DATA_WIDTH signed. Purely combinational.
module cic_comp_scale #(
    parameter int IN_WIDTH   = 65,
    parameter int SHIFT      = 48,
    parameter int DATA_WIDTH = 18
) (
    input  logic signed [IN_WIDTH-1:0]   in_i,
    output logic signed [DATA_WIDTH-1:0] x_o
);

    // One guard bit so adding the rounding constant cannot overflow.
    localparam int SW = IN_WIDTH + 1;
    localparam logic signed [SW-1:0] HALF = {{(SW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [SW-1:0] XMAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] XMIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] sum_w;
    logic signed [SW-1:0] sh_w;

    always_comb begin
        sum_w = {in_i[IN_WIDTH-1], in_i} + HALF;
        sh_w  = sum_w >>> SHIFT;
        if (sh_w > XMAX)
            x_o = XMAX[DATA_WIDTH-1:0];
        else if (sh_w < XMIN)
            x_o = XMIN[DATA_WIDTH-1:0];
        else
            x_o = sh_w[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR, decimate-by-DECIM, shared-coefficient serial MACs for I/Q.
// Build option CIC_COMP_SATURATE_EN: clamp the output instead of two's-complement wrap.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int IN_WIDTH   = 65,
    parameter int SHIFT      = 48,
    parameter int DATA_WIDTH = 18,
    parameter int COEF_WIDTH = CIC_COEF_W,
    parameter int OUT_WIDTH  = 16,
    parameter int DECIM      = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic signed [IN_WIDTH-1:0]  i_inph_data,
    input  logic signed [IN_WIDTH-1:0]  i_quad_data,
    input  logic                        i_valid,
    output logic signed [OUT_WIDTH-1:0] o_inph_data,
    output logic signed [OUT_WIDTH-1:0] o_quad_data,
    output logic                        o_valid,
    output logic                        o_overrun
);

    localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, NTAPS);
    localparam int PTR_W = $clog2(NTAPS);
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(NTAPS - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);
    localparam logic signed [ACC_W-1:0] RHALF = ACC_W'(1) << (COEF_WIDTH - 2);

    typedef logic signed [DATA_WIDTH-1:0] smp_t;

    smp_t                        xi, xq;
    smp_t                        dl_i_q [NTAPS];
    smp_t                        dl_q_q [NTAPS];
    state_t                      state_q, state_d;
    logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d, k_q, k_d;
    logic [PH_W-1:0]             phase_q, phase_d;
    logic signed [ACC_W-1:0]     acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0]     rnd_i, rnd_q;
    logic signed [OUT_WIDTH-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic                        vld_q, vld_d, ovr_q, ovr_d, we;

    cic_comp_scale #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .DATA_WIDTH(DATA_WIDTH))
        u_scale_i (.in_i(i_inph_data), .x_o(xi));
    cic_comp_scale #(.IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .DATA_WIDTH(DATA_WIDTH))
        u_scale_q (.in_i(i_quad_data), .x_o(xq));

`ifdef CIC_COMP_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [OUT_WIDTH-1:0] lim(input logic signed [ACC_W-1:0] v);
        if (v > OMAX) return OMAX[OUT_WIDTH-1:0];
        if (v < OMIN) return OMIN[OUT_WIDTH-1:0];
        return v[OUT_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [OUT_WIDTH-1:0] lim(input logic signed [ACC_W-1:0] v);
        return OUT_WIDTH'(v);
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        k_d     = k_q;
        phase_d = phase_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        out_i_d = out_i_q;
        out_q_d = out_q_q;
        vld_d   = 1'b0;
        we      = 1'b0;
        // Anything arriving outside IDLE (including the ROUND cycle) is lost.
        ovr_d   = ovr_q | (i_valid && state_q != IDLE);
        rnd_i   = (acc_i_q + RHALF) >>> (COEF_WIDTH - 1);
        rnd_q   = (acc_q_q + RHALF) >>> (COEF_WIDTH - 1);
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    we      = 1'b1;
                    wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                    if (phase_q == '0) begin
                        state_d = MAC;
                        rptr_d  = wptr_q;
                        k_d     = '0;
                        acc_i_d = '0;
                        acc_q_d = '0;
                    end
                end
            end
            MAC: begin
                // Walk backwards from the newest sample so tap k pairs with COEF[k].
                acc_i_d = acc_i_q + dl_i_q[rptr_q] * COEF[k_q];
                acc_q_d = acc_q_q + dl_q_q[rptr_q] * COEF[k_q];
                rptr_d  = (rptr_q == '0) ? LAST : rptr_q - 1'b1;
                k_d     = k_q + 1'b1;
                if (k_q == LAST) state_d = ROUND;
            end
            ROUND: begin
                out_i_d = lim(rnd_i);
                out_q_d = lim(rnd_q);
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            k_q     <= '0;
            phase_q <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            for (int n = 0; n < NTAPS; n++) begin
                dl_i_q[n] <= '0;
                dl_q_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            k_q     <= k_d;
            phase_q <= phase_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            if (we) begin
                dl_i_q[wptr_q] <= xi;
                dl_q_q[wptr_q] <= xq;
            end
        end
    end

    assign o_inph_data = out_i_q;
    assign o_quad_data = out_q_q;
    assign o_valid     = vld_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: impulse, DC, count/latency, overrun, saturation, mid-MAC reset.
module tb_cic_comp_fir;
    import cic_comp_pkg::*;

    localparam int SP = 30;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vin = 1'b0;
    logic signed [64:0] di  = '0;
    logic signed [64:0] dq  = '0;
    logic signed [15:0] oi, oq;
    logic               ov, ovr;

    cic_comp_fir dut (
        .i_clock(clk), .i_reset(rst), .i_inph_data(di), .i_quad_data(dq), .i_valid(vin),
        .o_inph_data(oi), .o_quad_data(oq), .o_valid(ov), .o_overrun(ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int oi_q[$], oq_q[$], oc_q[$], ic_q[$];
    always @(negedge clk) if (ov) begin
        oi_q.push_back(int'(oi));
        oq_q.push_back(int'(oq));
        oc_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; vin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        oi_q.delete(); oq_q.delete(); oc_q.delete(); ic_q.delete();
    endtask

    task automatic send(input logic signed [64:0] a, input logic signed [64:0] b);
        @(posedge clk); #1;
        vin = 1'b1; di = a; dq = b;
        ic_q.push_back(cyc);
        @(posedge clk); #1;
        vin = 1'b0; di = '0; dq = '0;
        repeat (SP - 1) @(posedge clk);
    endtask

    // Impulse of scaled 2^14: I = +impulse, Q = -impulse (exercises half-up asymmetry).
    int imp_i [12] = '{-15, 65, -256, 512, -1024, 15360, -1024, 512, -256, 65, -15, 0};
    int imp_q [12] = '{16, -64, 256, -512, 1024, -15360, 1024, -512, 256, -64, 16, 0};

    logic signed [64:0] IMP, NIMP, ZERO, DC, NDC, FSP, FSN;
    int bad;

    initial begin
        IMP  = 65'sd1 <<< 62;
        NIMP = -IMP;
        ZERO = '0;
        DC   = 65'sd1000 <<< 48;
        NDC  = -DC;
        FSP  = {1'b0, {64{1'b1}}};
        FSN  = {1'b1, {64{1'b0}}};

        do_reset;
        @(negedge clk);
        chk("rst_vld", ov, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_oi", oi, 0);

        repeat (1000) @(posedge clk);
        chk("idle_nvld", oi_q.size(), 0);
        @(negedge clk);
        chk("idle_ovr", ovr, 0);

        do_reset;
        for (int n = 0; n < 24; n++) send(n == 0 ? IMP : ZERO, n == 0 ? NIMP : ZERO);
        chk("imp_cnt", oi_q.size(), 12);
        for (int n = 0; n < 12; n++) begin
            chk("imp_i", oi_q[n], imp_i[n]);
            chk("imp_q", oq_q[n], imp_q[n]);
        end

        do_reset;
        for (int n = 0; n < 200; n++) send(ZERO, ZERO);
        chk("cnt", oi_q.size(), 100);
        chk("lag0", oc_q[0] - ic_q[0], NTAPS + 2);
        bad = 0;
        for (int j = 0; j < 100 && j < oc_q.size(); j++)
            if (oc_q[j] - ic_q[2*j] != NTAPS + 2) bad++;
        chk("lag_bad", bad, 0);

        do_reset;
        for (int n = 0; n < 30; n++) send(DC, NDC);
        chk("dc_cnt", oi_q.size(), 15);
        chk("dc_first_i", oi_q[0], -1);
        chk("dc_first_q", oq_q[0], 1);
        chk("dc_i10", oi_q[10], 1564);
        chk("dc_q10", oq_q[10], -1564);
        chk("dc_i14", oi_q[14], 1564);
        chk("dc_q14", oq_q[14], -1564);

        do_reset;
        @(posedge clk); #1;
        vin = 1'b1; di = IMP; dq = NIMP;
        @(posedge clk); #1;
        di = FSP; dq = FSN;
        @(posedge clk); #1;
        vin = 1'b0; di = '0; dq = '0;
        repeat (SP) @(posedge clk);
        @(negedge clk);
        chk("b2b_ovr", ovr, 1);
        send(ZERO, ZERO);
        send(ZERO, ZERO);
        chk("b2b_cnt", oi_q.size(), 2);
        chk("b2b_i0", oi_q[0], -15);
        chk("b2b_i1", oi_q[1], 65);
        chk("b2b_q1", oq_q[1], -64);
        @(negedge clk);
        chk("b2b_ovr_sticky", ovr, 1);

        do_reset;
        @(negedge clk);
        chk("rst2_ovr", ovr, 0);
        chk("rst2_oi", oi, 0);
        chk("rst2_oq", oq, 0);
        chk("rst2_vld", ov, 0);

        // Full-scale input scales to +/-65536; the 1.56 gain overflows 16 bits.
        for (int n = 0; n < 30; n++) send(FSP, FSN);
        chk("sat_cnt", oi_q.size(), 15);
`ifdef CIC_COMP_SATURATE_EN
        chk("sat_i", oi_q[14], 32767);
        chk("sat_q", oq_q[14], -32768);
`else
        chk("wrap_i", oi_q[14], -28544);
        chk("wrap_q", oq_q[14], 28544);
`endif

        do_reset;
        @(posedge clk); #1;
        vin = 1'b1; di = IMP; dq = NIMP;
        @(posedge clk); #1;
        vin = 1'b0; di = '0; dq = '0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        chk("mr_nvld", oi_q.size(), 0);
        @(negedge clk);
        chk("mr_ovr", ovr, 0);
        for (int n = 0; n < 4; n++) send(n == 0 ? IMP : ZERO, n == 0 ? NIMP : ZERO);
        chk("mr_cnt", oi_q.size(), 2);
        chk("mr_i0", oi_q[0], imp_i[0]);
        chk("mr_q0", oq_q[0], imp_q[0]);
        chk("mr_i1", oi_q[1], imp_i[1]);
        chk("mr_q1", oq_q[1], imp_q[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
